// File: rtl/tree_pkg.sv
// tree_pkg: shared op codes, FSM states, node record and default node table.
package tree_pkg;
    typedef enum logic [1:0] {OP_ENTER, OP_FIELD, OP_EXIT, OP_NOP} op_t;
    typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;
    localparam int DEF_ID_W = 5;
    localparam int DEF_NODE_W = 2;
    localparam int DEF_NUM_NODES = 3;
    typedef struct packed {
        logic [DEF_ID_W-1:0] field_id;
        logic [DEF_NODE_W-1:0] parent;
    } node_data;
    // Entry 0 is the root; node1 = {id 1, parent 0}, node2 = {id 4, parent 1}.
    localparam node_data [DEF_NUM_NODES-1:0] DEF_NODES = '{'{5'd4, 2'd1}, '{5'd1, 2'd0}, '{5'd0, 2'd0}};
endpackage

// File: rtl/tree_path_tracker_if.sv
// tree_path_tracker_if: token input and result output handshakes.
interface tree_path_tracker_if #(
    parameter int ID_W = 5,
    parameter int NODE_W = 2,
    parameter int DEPTH_W = 2
);
    import tree_pkg::*;
    logic in_valid, in_ready;
    op_t in_op;
    logic [ID_W-1:0] in_id;
    logic out_valid, out_ready, out_hit, out_overflow, out_underflow;
    logic [NODE_W-1:0] out_node;
    logic [DEPTH_W-1:0] out_depth;
    modport master (
        output in_valid, in_op, in_id, out_ready,
        input in_ready, out_valid, out_hit, out_node, out_depth, out_overflow, out_underflow
    );
    modport slave (
        input in_valid, in_op, in_id, out_ready,
        output in_ready, out_valid, out_hit, out_node, out_depth, out_overflow, out_underflow
    );
endinterface

// File: rtl/tree_path_stack.sv
// tree_path_stack: shift-register node stack with depth counter; top sits in slot 0.
module tree_path_stack #(
    parameter int MAX_DEPTH = 2,
    parameter int NODE_W = 2,
    localparam int DEPTH_W = $clog2(MAX_DEPTH + 1)
) (
    input logic clk,
    input logic rst_n,
    input logic push,
    input logic pop,
    input logic [NODE_W-1:0] push_node,
    output logic [DEPTH_W-1:0] depth,
    output logic [NODE_W-1:0] top,
    output logic full,
    output logic empty
);
    logic [NODE_W-1:0] stk [MAX_DEPTH];
    // Pops shift zero in from the bottom, so top reads 0 whenever the stack is empty.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            depth <= '0;
            for (int i = 0; i < MAX_DEPTH; i++) stk[i] <= '0;
        end else if (push) begin
            stk[0] <= push_node;
            for (int i = 1; i < MAX_DEPTH; i++) stk[i] <= stk[i-1];
            depth <= depth + 1'b1;
        end else if (pop) begin
            for (int i = 0; i < MAX_DEPTH - 1; i++) stk[i] <= stk[i+1];
            stk[MAX_DEPTH-1] <= '0;
            depth <= depth - 1'b1;
        end
    end
    assign top = stk[0];
    assign full = depth == DEPTH_W'(MAX_DEPTH);
    assign empty = depth == '0;
endmodule

// File: rtl/tree_path_tracker.sv
// tree_path_tracker: resolves field tokens against a parent-linked node table and tracks nesting.
module tree_path_tracker
    import tree_pkg::*;
#(
    parameter int ID_W = 5,
    parameter int NUM_NODES = 3,
    parameter int MAX_DEPTH = 2,
    localparam int NODE_W = NUM_NODES > 1 ? $clog2(NUM_NODES) : 1,
    localparam int DEPTH_W = $clog2(MAX_DEPTH + 1)
) (
    input logic clk,
    input logic rst_n,
    input logic [NUM_NODES*ID_W-1:0] tbl_field_id,
    input logic [NUM_NODES*NODE_W-1:0] tbl_parent,
    tree_path_tracker_if.slave bus
);
    state_t state, next;
    op_t op_q;
    logic [ID_W-1:0] id_q;
    logic [NODE_W-1:0] idx, top, res_node;
    logic res_hit, res_ovf, res_unf;
    logic [DEPTH_W-1:0] depth;
    logic full, empty, hit, accept, search_end, push, pop;
    logic [ID_W-1:0] fid [NUM_NODES];
    logic [NODE_W-1:0] par [NUM_NODES];
    for (genvar g = 0; g < NUM_NODES; g++) begin : g_tbl
        assign fid[g] = tbl_field_id[g*ID_W +: ID_W];
        assign par[g] = tbl_parent[g*NODE_W +: NODE_W];
    end
    assign hit = fid[idx] == id_q && par[idx] == top;
    assign accept = bus.in_valid && state == IDLE;
    assign search_end = state == SEARCH && (hit || idx == NODE_W'(NUM_NODES - 1));
    assign push = search_end && hit && op_q == OP_ENTER && !full;
    assign pop = accept && bus.in_op == OP_EXIT && !empty;
    tree_path_stack #(.MAX_DEPTH(MAX_DEPTH), .NODE_W(NODE_W)) u_stack (
        .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .push_node(idx),
        .depth(depth), .top(top), .full(full), .empty(empty)
    );
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else state <= next;
    end
    always_comb begin
        next = state == IDLE ? (accept ? (bus.in_op inside {OP_ENTER, OP_FIELD} ? SEARCH : DONE) : IDLE)
             : state == SEARCH ? (search_end ? DONE : SEARCH)
             : (bus.out_ready ? IDLE : DONE);
    end
    always_comb begin
        bus.in_ready = state == IDLE;
        bus.out_valid = state == DONE;
        bus.out_hit = res_hit;
        bus.out_node = res_node;
        bus.out_depth = depth;
        bus.out_overflow = res_ovf;
        bus.out_underflow = res_unf;
    end
    // EXIT/NOP results are final at acceptance; search ops overwrite them when the scan ends.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q <= OP_NOP;
            id_q <= '0;
            idx <= '0;
            res_hit <= 1'b0;
            res_node <= '0;
            res_ovf <= 1'b0;
            res_unf <= 1'b0;
        end else if (accept) begin
            op_q <= bus.in_op;
            id_q <= bus.in_id;
            idx <= NODE_W'(1);
            res_hit <= bus.in_op == OP_EXIT && !empty;
            res_node <= bus.in_op == OP_EXIT ? top : '0;
            res_ovf <= 1'b0;
            res_unf <= bus.in_op == OP_EXIT && empty;
        end else if (state == SEARCH) begin
            idx <= idx + 1'b1;
            if (search_end) begin
                res_hit <= hit;
                res_node <= hit ? idx : '0;
                res_ovf <= hit && op_q == OP_ENTER && full;
                res_unf <= 1'b0;
            end
        end
    end
endmodule

// File: doc/tree_path_tracker.md
TREE_PATH_TRACKER -- requirements
Module: tree_path_tracker

Interface
REQ-001 SHALL have parameter ID_W, default 5, field identifier width.
REQ-002 SHALL have parameter NUM_NODES, default 3, node table entries; entry 0 is the null/root node.
REQ-003 SHALL have parameter MAX_DEPTH, default 2, maximum message nesting depth.
REQ-004 SHALL derive NODE_W = max(1, clog2(NUM_NODES)) and DEPTH_W = clog2(MAX_DEPTH+1).
REQ-005 SHALL have ports clk (in, 1, clock) and rst_n (in, 1, reset); one clock; reset is synchronous and active-low.
REQ-006 SHALL have tbl_field_id (in, NUM_NODES*ID_W, field id per node) and tbl_parent (in, NUM_NODES*NODE_W, parent node index per node), both static in operation.
REQ-007 SHALL have in_valid (in, 1), in_ready (out, 1), in_op (in, 2, op_t), in_id (in, ID_W): the token input.
REQ-008 SHALL have out_valid (in: out, 1), out_ready (in, 1), out_hit (out, 1), out_node (out, NODE_W), out_depth (out, DEPTH_W), out_overflow (out, 1), out_underflow (out, 1).

Function
REQ-009 SHALL implement the FSM IDLE, SEARCH, DONE; in_ready = 1 only in IDLE; a token is accepted when in_valid and in_ready are both 1.
REQ-010 SHALL treat OP_ENTER (submessage start) and OP_FIELD (scalar field) as search ops: accept -> SEARCH with idx = 1.
REQ-011 SHALL, in SEARCH, compare one entry per cycle; hit = tbl_field_id[idx] == in_id (latched) and tbl_parent[idx] == top, where top = 0 when depth = 0, else stack[depth-1].
REQ-012 SHALL go to DONE on the cycle after the first hit (lowest index wins) or after idx = NUM_NODES-1 is compared without a hit; latency from acceptance to out_valid is idx_hit+1 cycles, or NUM_NODES on a miss.
REQ-013 SHALL treat OP_EXIT as the pop op: accept -> DONE next cycle, with out_node = the popped node and out_hit = 1.
REQ-014 SHALL treat op value 3 as OP_NOP: accept -> DONE with out_hit = 0 and state unchanged.
REQ-015 SHALL, on an OP_ENTER hit with depth < MAX_DEPTH, push the hit index and increment depth.
REQ-016 SHALL, on an OP_ENTER hit with depth = MAX_DEPTH, report out_hit = 1 and out_overflow = 1, with no push.
REQ-017 SHALL not change the stack on an OP_FIELD hit.
REQ-018 SHALL, on any miss, drive out_hit = 0 and out_node = 0, with the stack unchanged.
REQ-019 SHALL, on OP_EXIT at depth 0, drive out_underflow = 1, out_hit = 0 and out_node = 0, with depth kept at 0.
REQ-020 SHALL apply stack updates on the SEARCH/EXIT-to-DONE transition; out_depth shows the post-update depth.
REQ-021 SHALL hold out_valid and all out_* stable in DONE until out_ready = 1, then go to IDLE on the next cycle.
REQ-022 SHALL set error flags only in the single affected result; the flags are not sticky.

Reset
REQ-023 SHALL, when rst_n = 0 at a clk edge, set state = IDLE, depth = 0, and all stack entries = 0.
REQ-024 SHALL, in the same reset, drive out_valid = 0, out_hit = 0, out_node = 0, out_depth = 0 and both error flags = 0.
REQ-025 SHALL have reset take priority in any state, including mid-SEARCH; the in-flight token is discarded with no result.

Structure
REQ-026 SHALL define op_t (OP_ENTER = 0, OP_FIELD = 1, OP_EXIT = 2, OP_NOP = 3), the node_data struct (field_id, parent) and the default node table constants in shared package tree_pkg.
REQ-027 SHALL implement the push/pop storage, depth counter and top-of-stack output as sub-module tree_path_stack, parameterised by MAX_DEPTH and NODE_W.

Verification
(Table for all scenarios: node1 = {id 1, parent 0}, node2 = {id 4, parent 1}.)
REQ-028 SHALL cover: after reset, ENTER id=1 accepted at cycle 0 -> out_valid at cycle 2, hit = 1, node = 1, depth = 1.
REQ-029 SHALL cover: then ENTER id=4 -> node = 2, depth = 2; then FIELD id=1 -> latency 3, hit = 0, node = 0, depth = 2 (parent mismatch).
REQ-030 SHALL cover: MAX_DEPTH = 1, ENTER id=1 then ENTER id=4 -> second result hit = 1, node = 2, overflow = 1, depth = 1.
REQ-031 SHALL cover: EXIT at depth 0 -> underflow = 1, hit = 0, depth = 0; then EXIT after ENTER id=1 -> node = 1, depth = 0.
REQ-032 SHALL cover: out_ready held 0 for 5 cycles in DONE -> out_* stable and in_ready = 0 throughout; out_ready = 1 -> in_ready = 1 the next cycle.
REQ-033 SHALL cover: rst_n = 0 during SEARCH at depth 1 -> next cycle out_valid = 0, depth = 0, in_ready = 1, and no result is emitted.
